// File: rtl/mem_port_if.sv
// mem_port_if: external memory bus between mem_port (master) and the memory (slave).
//
// Handshake: the master raises bus_req with bus_we/bus_adr/bus_wdata stable and
// holds all four until it samples bus_ack high on a rising clk edge; that edge
// completes the transfer (bus_rdata is valid in the same cycle as bus_ack on reads).
// bus_ack is meaningful only while bus_req is high and is ignored otherwise.
interface mem_port_if #(
   parameter int WIDTH = 8
) ();
   logic             bus_req;
   logic             bus_we;
   logic [WIDTH-1:0] bus_adr;
   logic [WIDTH-1:0] bus_wdata;
   logic [WIDTH-1:0] bus_rdata;
   logic             bus_ack;

   modport master (
      output bus_req, bus_we, bus_adr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_adr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_port.sv
// mem_port: turns the multicycle controller's memread/memwrite strobes into one
// req/ack transaction on the external bus, registers read data into memdata and
// holds the controller (stall) while an access is outstanding.
// Optional macro MEM_TIMEOUT_EN: abort a request after TIMEOUT cycles without ack,
// pulsing err with done and returning all-ones read data.
module mem_port #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 15,
   parameter int CNTW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             memread,
   input  logic             memwrite,
   input  logic [WIDTH-1:0] adr,
   input  logic [WIDTH-1:0] writedata,
   output logic [WIDTH-1:0] memdata,
   output logic             stall,
   output logic             done,
   output logic             err,
   output logic [1:0]       state_dbg,
   mem_port_if.master       bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   logic   strobe;

   assign strobe    = memread | memwrite;
   assign state_dbg = state;

`ifdef MEM_TIMEOUT_EN
   logic [CNTW-1:0] cnt;
   logic            timeout_hit;

   // The edge ending the TIMEOUT-th request cycle without ack is the abort edge.
   assign timeout_hit = (cnt == CNTW'(TIMEOUT - 1));
`else
   logic [CNTW-1:0] unused_timeout;

   assign unused_timeout = CNTW'(TIMEOUT);
   assign err            = 1'b0;
`endif

   // Hold the controller the same cycle a strobe shows up and for the whole request.
   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         case (state)
            IDLE:    stall = strobe;
            REQ:     stall = 1'b1;
            default: stall = 1'b0;
         endcase
      end
   end

   // Transaction FSM with registered bus outputs, read-data register and done/err pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         memdata       <= '0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_adr   <= '0;
         bus.bus_wdata <= '0;
         done          <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         err           <= 1'b0;
         cnt           <= '0;
`endif
      end else begin
         done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (strobe) begin
                  // Write wins when both strobes are high.
                  bus.bus_adr   <= adr;
                  bus.bus_wdata <= writedata;
                  bus.bus_we    <= memwrite;
                  bus.bus_req   <= 1'b1;
                  state         <= REQ;
`ifdef MEM_TIMEOUT_EN
                  cnt           <= '0;
`endif
               end
            end
            REQ: begin
               if (bus.bus_ack) begin
                  if (!bus.bus_we) begin
                     memdata <= bus.bus_rdata;
                  end
                  bus.bus_req <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (timeout_hit) begin
                  if (!bus.bus_we) begin
                     memdata <= '1;
                  end
                  bus.bus_req <= 1'b0;
                  done        <= 1'b1;
                  err         <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               // Strobes still high here belong to the access that just finished.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
